// File: rtl/spi_byte_sequencer_if.sv
// Byte-level handshake between spi_byte_sequencer and the SPI master core.
//   spi_start      sequencer -> core  request to begin shifting one byte
//   spi_rdata      sequencer -> core  byte to transmit, stable for the transfer
//   spi_c_div      sequencer -> core  clock divide select latched at launch
//   spi_lsb_msb    sequencer -> core  bit order latched at launch (1 = MSB first)
//   spi_wb_finish  sequencer -> core  one-cycle write-back acknowledge
//   spi_tdata      core -> sequencer  received byte
//   spi_ss         core -> sequencer  slave select, low while shifting
// Modport master is the sequencer side; modport slave is the core side.
interface spi_byte_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_rdata;
  logic [1:0] spi_c_div;
  logic       spi_lsb_msb;
  logic       spi_wb_finish;
  logic [7:0] spi_tdata;
  logic       spi_ss;

  modport master (
    output spi_start, spi_rdata, spi_c_div, spi_lsb_msb, spi_wb_finish,
    input  spi_tdata, spi_ss
  );

  modport slave (
    input  spi_start, spi_rdata, spi_c_div, spi_lsb_msb, spi_wb_finish,
    output spi_tdata, spi_ss
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Host-side front end for an SPI master core. Host bytes are queued in a TX
// FIFO and issued one at a time over the start / slave-select / write-back
// handshake; each received byte is queued in an RX FIFO for the host.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            permits new launches (never aborts a running transfer)
//   cfg_div, cfg_msb  divide select and bit order, latched at each launch
//   tx_wdata, tx_wr   host push into the TX FIFO
//   tx_full, tx_level TX FIFO status
//   rx_rdata, rx_rd   RX FIFO show-ahead head and pop
//   rx_empty,rx_level RX FIFO status
//   tx_overflow       sticky: push attempted while TX full; err_clr clears it
//   busy              high whenever a transfer is in progress
//   spi               handshake to the SPI master core
module spi_byte_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [1:0]    cfg_div,
  input  logic          cfg_msb,
  input  logic [7:0]    tx_wdata,
  input  logic          tx_wr,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  output logic [7:0]    rx_rdata,
  input  logic          rx_rd,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          tx_overflow,
  input  logic          err_clr,
  output logic          busy,
  spi_byte_sequencer_if.master spi
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_XFER, S_CAPTURE, S_ACK, S_GAP
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;

  logic tx_pop, tx_push, rx_push, rx_pop;

  // A launch also reserves one RX slot: no host push into RX exists, so
  // requiring space at launch guarantees the capture always fits.
  assign tx_pop  = (state == S_IDLE) && enable && (tx_level != '0) && (rx_level != LVL_FULL);
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign tx_push = tx_wr && ((tx_level != LVL_FULL) || tx_pop);
  assign rx_push = (state == S_CAPTURE);
  assign rx_pop  = rx_rd && (rx_level != '0);

  assign tx_full  = (tx_level == LVL_FULL);
  assign rx_empty = (rx_level == '0);
  assign rx_rdata = rx_mem[rx_rd_ptr];

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_wdata;
    if (rx_push) rx_mem[rx_wr_ptr] <= spi.spi_tdata;
  end

  // FIFO pointers, levels and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_level    <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_level    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + LVL_ONE;
        2'b01:   tx_level <= tx_level - LVL_ONE;
        default: tx_level <= tx_level;
      endcase

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LVL_ONE;
        2'b01:   rx_level <= rx_level - LVL_ONE;
        default: rx_level <= rx_level;
      endcase

      // A fresh overflow takes priority over a clear in the same cycle.
      if (tx_wr && !tx_push) tx_overflow <= 1'b1;
      else if (err_clr)      tx_overflow <= 1'b0;
    end
  end

  // Transfer sequencing; all handshake outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      gap_cnt           <= '0;
      busy              <= 1'b0;
      spi.spi_start     <= 1'b0;
      spi.spi_wb_finish <= 1'b0;
      spi.spi_rdata     <= '0;
      spi.spi_c_div     <= '0;
      spi.spi_lsb_msb   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_pop) begin
            spi.spi_rdata   <= tx_mem[tx_rd_ptr];
            spi.spi_c_div   <= cfg_div;
            spi.spi_lsb_msb <= cfg_msb;
            spi.spi_start   <= 1'b1;
            busy            <= 1'b1;
            state           <= S_START;
          end
        end
        S_START: begin
          if (!spi.spi_ss) begin
            spi.spi_start <= 1'b0;
            state         <= S_XFER;
          end
        end
        S_XFER: begin
          if (spi.spi_ss) state <= S_CAPTURE;
        end
        // spi_tdata has had a full cycle since ss rose; the push happens here.
        S_CAPTURE: begin
          spi.spi_wb_finish <= 1'b1;
          state             <= S_ACK;
        end
        S_ACK: begin
          spi.spi_wb_finish <= 1'b0;
          gap_cnt           <= GAP_LOAD;
          state             <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: SPI core model, timestamp-based reference
// model with an every-cycle comparator, and directed plus random scenarios.
module tb_spi_byte_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int GAP   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    cfg_div = 2'd0;
  logic          cfg_msb = 1'b0;
  logic [7:0]    tx_wdata = 8'd0;
  logic          tx_wr = 1'b0;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic [7:0]    rx_rdata;
  logic          rx_rd = 1'b0;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          tx_overflow;
  logic          err_clr = 1'b0;
  logic          busy;

  spi_byte_sequencer_if sif();

  spi_byte_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_div(cfg_div), .cfg_msb(cfg_msb),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_level(rx_level),
    .tx_overflow(tx_overflow), .err_clr(err_clr), .busy(busy), .spi(sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- SPI core model ----------------
  bit rand_mask = 1'b0;

  initial begin : core_model
    int lat;
    int len;
    sif.spi_ss = 1'b1;
    sif.spi_tdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && sif.spi_start && sif.spi_ss) begin
        lat = int'($urandom_range(2, 0));
        len = int'($urandom_range(6, 1));
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst) break;
        end
        sif.spi_ss = 1'b0;
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          if (rst) break;
        end
        sif.spi_tdata = sif.spi_rdata ^ (rand_mask ? 8'($urandom) : 8'h00);
        sif.spi_ss = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Transfers are tracked by edge timestamps: launch, ss-low seen, ss-high
  // seen (capture is the following edge), then ack and GAP idle edges.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_ovf, m_busy, m_start, m_wb, m_msb;
  logic [7:0] m_rdata;
  logic [1:0] m_div;
  bit         active, got_low, model_ok;
  int         cap_edge = -1;
  int         cyc = 0;

  always @(posedge clk) begin : model
    int pre_tx, pre_rx;
    bit launch, rxp, cap, txp;
    cyc++;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_ovf = 0; m_busy = 0; m_start = 0; m_wb = 0;
      m_rdata = 8'h00; m_div = 2'd0; m_msb = 0;
      active = 0; got_low = 0; cap_edge = -1; model_ok = 1;
    end else begin
      pre_tx = txq.size();
      pre_rx = rxq.size();
      launch = !active && enable && pre_tx > 0 && pre_rx < DEPTH;
      rxp    = rx_rd && pre_rx > 0;
      cap    = active && (cap_edge == cyc);
      txp    = tx_wr && (pre_tx < DEPTH || launch);
      if (rxp) void'(rxq.pop_front());
      if (cap) rxq.push_back(sif.spi_tdata);
      m_wb = cap;
      if (active) begin
        if (!got_low) begin
          if (!sif.spi_ss) begin got_low = 1; m_start = 0; end
        end else if (cap_edge < 0) begin
          if (sif.spi_ss) cap_edge = cyc + 1;
        end else if (cyc == cap_edge + 1 + GAP) begin
          active = 0; m_busy = 0;
        end
      end else if (launch) begin
        m_rdata = txq.pop_front();
        m_div = cfg_div; m_msb = cfg_msb;
        active = 1; got_low = 0; cap_edge = -1;
        m_start = 1; m_busy = 1;
      end
      if (txp) txq.push_back(tx_wdata);
      if (tx_wr && !txp) m_ovf = 1;
      else if (err_clr) m_ovf = 0;
    end
  end

  // ---------------- every-cycle comparator ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("tx_level", 32'(tx_level), 32'(txq.size()));
      chk("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
      chk("rx_level", 32'(rx_level), 32'(rxq.size()));
      chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
      if (rxq.size() > 0) chk("rx_rdata", 32'(rx_rdata), 32'(rxq[0]));
      chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("spi_start", 32'(sif.spi_start), 32'(m_start));
      chk("spi_wb_finish", 32'(sif.spi_wb_finish), 32'(m_wb));
      chk("spi_rdata", 32'(sif.spi_rdata), 32'(m_rdata));
      chk("spi_c_div", 32'(sif.spi_c_div), 32'(m_div));
      chk("spi_lsb_msb", 32'(sif.spi_lsb_msb), 32'(m_msb));
    end
  end

  // ---------------- event counters / spacing ----------------
  int   starts = 0, wbs = 0, last_wb = -1, ncyc = 0;
  bit   spacing_on = 1'b0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (!spacing_on) last_wb = -1;
    if (sif.spi_wb_finish) begin wbs++; last_wb = ncyc; end
    if (sif.spi_start && !prev_start) begin
      starts++;
      if (spacing_on && last_wb >= 0) chk("wb_to_start_gap", 32'(ncyc - last_wb), 32'(GAP + 2));
    end
    prev_start = sif.spi_start;
  end

  // ---------------- helpers ----------------
  task automatic push(input logic [7:0] b);
    tx_wdata = b; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      rx_rd = !rx_empty;
      @(negedge clk);
    end
    rx_rd = 1'b0;
  endtask

  task automatic wait_ss_low(input string name);
    int t;
    t = 0;
    while (sif.spi_ss && t < 40) begin @(negedge clk); t++; end
    chk(name, 32'(sif.spi_ss), 32'(0));
  endtask

  int s0, w0, t;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0; enable = 1'b1; cfg_div = 2'd0; cfg_msb = 1'b1;
    chk("reset_tx_full", 32'(tx_full), 32'(0));
    chk("reset_rx_empty", 32'(rx_empty), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_ovf", 32'(tx_overflow), 32'(0));
    @(negedge clk);

    // single byte, loopback
    s0 = starts; w0 = wbs;
    tx_wdata = 8'hA5; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("latency_cycle1_start", 32'(sif.spi_start), 32'(0));
    @(negedge clk);
    chk("latency_cycle2_start", 32'(sif.spi_start), 32'(1));
    chk("single_spi_rdata", 32'(sif.spi_rdata), 32'(8'hA5));
    repeat (30) @(negedge clk);
    chk("single_rx_rdata", 32'(rx_rdata), 32'(8'hA5));
    chk("single_rx_level", 32'(rx_level), 32'(1));
    chk("single_busy", 32'(busy), 32'(0));
    chk("single_starts", 32'(starts - s0), 32'(1));
    chk("single_wb_cycles", 32'(wbs - w0), 32'(1));
    drain(3);

    // burst with overflow
    enable = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("burst_tx_full", 32'(tx_full), 32'(1));
    chk("burst_tx_level", 32'(tx_level), 32'(8));
    push(8'h99);
    chk("burst_overflow", 32'(tx_overflow), 32'(1));
    chk("burst_level_after_ovf", 32'(tx_level), 32'(8));
    spacing_on = 1'b1; enable = 1'b1;
    repeat (200) @(negedge clk);
    spacing_on = 1'b0;
    chk("burst_rx_level", 32'(rx_level), 32'(8));
    chk("burst_tx_empty", 32'(tx_level), 32'(0));
    rx_rd = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("burst_rx_order", 32'(rx_rdata), 32'(i));
      @(negedge clk);
    end
    rx_rd = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("burst_err_clr", 32'(tx_overflow), 32'(0));

    // RX backpressure
    enable = 1'b0;
    s0 = starts;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    enable = 1'b1;
    repeat (125) @(negedge clk);
    for (int i = 5; i < 10; i++) push(8'h10 + 8'(i));
    repeat (250) @(negedge clk);
    chk("bp_busy", 32'(busy), 32'(0));
    chk("bp_tx_level", 32'(tx_level), 32'(2));
    chk("bp_rx_level", 32'(rx_level), 32'(8));
    chk("bp_starts", 32'(starts - s0), 32'(8));
    s0 = starts;
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    repeat (40) @(negedge clk);
    chk("bp_one_more_start", 32'(starts - s0), 32'(1));
    chk("bp_tx_level_after", 32'(tx_level), 32'(1));
    drain(120);

    // config latch
    cfg_msb = 1'b0; cfg_div = 2'd3;
    push(8'h3C);
    wait_ss_low("cfg_xfer_seen");
    cfg_msb = 1'b1; cfg_div = 2'd1;
    @(negedge clk);
    chk("cfg_div_held", 32'(sif.spi_c_div), 32'(3));
    chk("cfg_msb_held", 32'(sif.spi_lsb_msb), 32'(0));
    repeat (30) @(negedge clk);
    chk("cfg_div_idle", 32'(sif.spi_c_div), 32'(3));
    push(8'h3D);
    repeat (30) @(negedge clk);
    chk("cfg_div_next", 32'(sif.spi_c_div), 32'(1));
    chk("cfg_msb_next", 32'(sif.spi_lsb_msb), 32'(1));
    drain(5);

    // simultaneous push on full with internal pop; rx_rd with capture
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    enable = 1'b1; tx_wdata = 8'h48; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("simul_tx_level", 32'(tx_level), 32'(8));
    chk("simul_no_ovf", 32'(tx_overflow), 32'(0));
    chk("simul_started", 32'(sif.spi_start), 32'(1));
    t = 0;
    while (rx_level != 1 && t < 60) begin @(negedge clk); t++; end
    chk("simul_first_capture", 32'(rx_level), 32'(1));
    t = 0;
    while (!(active && cap_edge > cyc) && t < 60) begin @(negedge clk); t++; end
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    chk("simul_rx_level", 32'(rx_level), 32'(1));
    drain(300);

    // reset in the middle of a transfer
    push(8'h77);
    push(8'h78);
    wait_ss_low("rst_xfer_seen");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_spi_start", 32'(sif.spi_start), 32'(0));
    chk("rst_wb", 32'(sif.spi_wb_finish), 32'(0));
    chk("rst_tx_level", 32'(tx_level), 32'(0));
    chk("rst_rx_empty", 32'(rx_empty), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    s0 = starts;
    repeat (30) @(negedge clk);
    chk("rst_no_spurious_start", 32'(starts - s0), 32'(0));

    // randomized traffic
    rand_mask = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tx_wr    = ($urandom_range(2, 0) == 0);
      tx_wdata = 8'($urandom);
      rx_rd    = ($urandom_range(2, 0) == 0);
      enable   = ($urandom_range(7, 0) != 0);
      cfg_div  = 2'($urandom);
      cfg_msb  = 1'($urandom);
      err_clr  = ($urandom_range(15, 0) == 0);
      @(negedge clk);
    end
    tx_wr = 1'b0; err_clr = 1'b0; enable = 1'b1;
    drain(300);
    chk("random_end_idle", 32'(busy), 32'(0));
    chk("random_end_tx_empty", 32'(tx_level), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
